// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared oscilloscope types and widths
package osc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meter_state_t;

  // Same width as the clock divider counter, so any divider setting can be measured back.
  localparam int METER_WIDTH_DEFAULT = 17;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - control and measurement bundle of the period meter
interface period_meter_if
  import osc_pkg::*;
#(
  parameter int WIDTH = METER_WIDTH_DEFAULT
);
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] div_count;
  logic             odd;
  logic             valid;
  logic             timeout;

  modport master (
    output enable, sig_in,
    input  period, high_time, div_count, odd, valid, timeout
  );

  modport slave (
    input  enable, sig_in,
    output period, high_time, div_count, odd, valid, timeout
  );
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - synchronizer for an asynchronous input with rise/fall detect
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   s_d_q, s_d_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
    s_d_d   = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      s_d_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      s_d_q   <= s_d_d;
    end
  end

  assign s    = chain_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;
endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of an async square wave in clk cycles
module period_meter
  import osc_pkg::*;
#(
  parameter int WIDTH       = METER_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  period_meter_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic s_unused, rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.sig_in),
    .s        (s_unused),
    .rise     (rise),
    .fall     (fall)
  );

  meter_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic             seen_fall_q, seen_fall_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic [WIDTH-1:0] div_count_q, div_count_d;
  logic             odd_q, odd_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    seen_fall_d = seen_fall_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    div_count_d = div_count_q;
    odd_d       = odd_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!bus.enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hi_cap_d    = '0;
      seen_fall_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            cnt_d       = CNT_ONE;
            hi_cap_d    = '0;
            seen_fall_d = 1'b0;
            state_d     = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            // Restart the count on the same edge so back-to-back periods lose no cycle.
            period_d    = cnt_q;
            high_time_d = hi_cap_q;
            div_count_d = cnt_q >> 1;
            odd_d       = cnt_q[0];
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = CNT_ONE;
            seen_fall_d = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall && !seen_fall_q) begin
              hi_cap_d    = cnt_q;
              seen_fall_d = 1'b1;
            end
          end
        end
        default: state_d = ARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARM;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      seen_fall_q <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      div_count_q <= '0;
      odd_q       <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      seen_fall_q <= seen_fall_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      div_count_q <= div_count_d;
      odd_q       <= odd_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.div_count = div_count_q;
  assign bus.odd       = odd_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
endmodule
